// File: rtl/counter_pkg.sv
// counter_pkg: shared select encoding and default width for up_down_counter_n
package counter_pkg;
  localparam int DEF_WIDTH = 8;
  typedef enum logic [1:0] {SEL_CLR, SEL_LD, SEL_CNT, SEL_HOLD} sel_e;
endpackage

// File: rtl/up_down_counter_n_if.sv
// up_down_counter_n_if: control, load and status signals of the counter
interface up_down_counter_n_if #(parameter int WIDTH = 8);
  logic en;
  logic up;
  logic ctr_rst;
  logic ld;
  logic [WIDTH-1:0] ld_val;
  logic [WIDTH-1:0] out;
  logic tc;
  logic err;
  modport master (output en, up, ctr_rst, ld, ld_val, input out, tc, err);
  modport slave (input en, up, ctr_rst, ld, ld_val, output out, tc, err);
endinterface

// File: rtl/dffr_n.sv
// dffr_n: single-bit flop, asynchronous active-low reset to 0
module dffr_n (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  always_ff @(posedge clk or negedge rst)
    if (!rst) q <= 1'b0;
    else q <= d;
endmodule

// File: rtl/up_down_counter_n.sv
// up_down_counter_n: wrapping up/down counter with clear, checked load and sticky err;
// define UP_DOWN_COUNTER_SAT_EN to saturate at 0 and MAX_VAL instead of wrapping
module up_down_counter_n
  import counter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter logic [WIDTH-1:0] MAX_VAL = '1
) (
  input logic clk,
  input logic rst,
  up_down_counter_n_if.slave bus
);
  localparam logic [WIDTH:0] ONE = {{WIDTH{1'b0}}, 1'b1};
  logic [WIDTH:0] state_d, state_q, nxt, room;
  logic [WIDTH-1:0] cnt_q, wrap, step;
  logic err_q, ld_ok, at_end;
  sel_e sel;
  assign cnt_q = state_q[WIDTH-1:0];
  assign err_q = state_q[WIDTH];
  // err sits in the top bit so count and flag share one flop array
  dffr_n u_ff [WIDTH:0] (.clk(clk), .rst(rst), .d(state_d), .q(state_q));
  always_comb begin
    state_d = state_q;
    sel = bus.ctr_rst ? SEL_CLR : bus.ld ? SEL_LD : bus.en ? SEL_CNT : SEL_HOLD;
    room = {1'b0, MAX_VAL} - {1'b0, bus.ld_val};
    ld_ok = !room[WIDTH];
    nxt = bus.up ? {1'b0, cnt_q} + ONE : {1'b0, cnt_q} - ONE;
    at_end = bus.up ? nxt > {1'b0, MAX_VAL} : nxt[WIDTH];
`ifdef UP_DOWN_COUNTER_SAT_EN
    wrap = cnt_q;
`else
    wrap = bus.up ? '0 : MAX_VAL;
`endif
    step = at_end ? wrap : nxt[WIDTH-1:0];
    state_d[WIDTH-1:0] = sel == SEL_CLR ? '0 :
                         sel == SEL_LD  ? (ld_ok ? bus.ld_val : cnt_q) :
                         sel == SEL_CNT ? step : cnt_q;
    state_d[WIDTH] = sel != SEL_CLR && (err_q || (sel == SEL_LD && !ld_ok));
  end
  assign bus.out = cnt_q;
  assign bus.tc = sel == SEL_CNT && at_end;
  assign bus.err = err_q;
endmodule
